// File: rtl/ldl_rr_arbiter.sv
// Registered round-robin arbiter: picks one requester per load cycle starting
// after the last granted index and presents it with a valid/ready handshake.
module ldl_rr_arbiter #(
  parameter  int unsigned BIN_WIDTH = 3,
  localparam int unsigned REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_WIDTH-1:0] req,
  input  logic                 ready,
  output logic                 valid,
  output logic [REQ_WIDTH-1:0] hot,
  output logic [BIN_WIDTH-1:0] bin
);

  logic                 valid_q;
  logic [REQ_WIDTH-1:0] hot_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BIN_WIDTH-1:0] ptr;

  logic                 load;
  logic                 found;
  logic [BIN_WIDTH-1:0] win;
  logic [BIN_WIDTH-1:0] cand;
  logic [REQ_WIDTH-1:0] hot_next;

  assign load = !valid_q || ready;

  // Search ptr+1 .. ptr+REQ_WIDTH; the BIN_WIDTH-bit add wraps naturally,
  // so ptr itself is the last candidate examined.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= REQ_WIDTH; i++) begin
      cand = ptr + BIN_WIDTH'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    hot_next      = '0;
    hot_next[win] = found;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      hot_q   <= '0;
      bin_q   <= '0;
      ptr     <= BIN_WIDTH'(REQ_WIDTH - 1);
    end else if (load) begin
      valid_q <= found;
      hot_q   <= hot_next;
      bin_q   <= win;
      if (found)
        ptr <= win;
    end
  end

  assign valid = valid_q;
  assign hot   = hot_q;
  assign bin   = bin_q;

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// Directed vector bench for ldl_rr_arbiter (8 requesters).
module tb_ldl_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [7:0] hot;
  logic [2:0] bin;

  int passed = 0;
  int total  = 0;

  ldl_rr_arbiter #(.BIN_WIDTH(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .ready(ready),
    .valid(valid),
    .hot  (hot),
    .bin  (bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_hot;
    logic [2:0] exp_bin;
    string      name;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, got, exp);
  endtask

  task automatic check_out(input string name, input logic ev, input logic [7:0] eh, input logic [2:0] eb);
    check({name, ".valid"}, {7'd0, valid}, {7'd0, ev});
    check({name, ".hot"},   hot,           eh);
    check({name, ".bin"},   {5'd0, bin},   {5'd0, eb});
  endtask

  // Invariant: hot is zero or one-hot and agrees with valid/bin.
  task automatic check_inv(input string name);
    logic ok;
    ok = valid ? (hot == (8'h01 << bin)) : (hot == 8'h00 && bin == 3'd0);
    check({name, ".inv"}, {7'd0, ok}, 8'h01);
  endtask

  task automatic step(input logic [7:0] r, input logic rd);
    req   = r;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Starting from ptr=7 after reset
    vecs[0]  = '{8'h01, 1'b1, 1'b1, 8'h01, 3'd0, "single0"};
    vecs[1]  = '{8'h01, 1'b1, 1'b1, 8'h01, 3'd0, "single1"};
    vecs[2]  = '{8'h01, 1'b1, 1'b1, 8'h01, 3'd0, "single2"};
    vecs[3]  = '{8'h03, 1'b1, 1'b1, 8'h02, 3'd1, "pair0"};
    vecs[4]  = '{8'h03, 1'b1, 1'b1, 8'h01, 3'd0, "pair1"};
    vecs[5]  = '{8'h03, 1'b1, 1'b1, 8'h02, 3'd1, "pair2"};
    vecs[6]  = '{8'h03, 1'b1, 1'b1, 8'h01, 3'd0, "pair3"};
    vecs[7]  = '{8'ha5, 1'b1, 1'b1, 8'h04, 3'd2, "sparse0"};
    vecs[8]  = '{8'ha5, 1'b1, 1'b1, 8'h20, 3'd5, "sparse1"};
    vecs[9]  = '{8'ha5, 1'b1, 1'b1, 8'h80, 3'd7, "sparse2"};
    vecs[10] = '{8'ha5, 1'b1, 1'b1, 8'h01, 3'd0, "sparse_wrap"};
    vecs[11] = '{8'ha5, 1'b1, 1'b1, 8'h04, 3'd2, "sparse4"};
    vecs[12] = '{8'ha5, 1'b0, 1'b1, 8'h04, 3'd2, "bp_hold"};
    vecs[13] = '{8'h01, 1'b0, 1'b1, 8'h04, 3'd2, "bp_req_drop"};
    vecs[14] = '{8'ha5, 1'b1, 1'b1, 8'h20, 3'd5, "bp_resume"};
    vecs[15] = '{8'ha5, 1'b1, 1'b1, 8'h80, 3'd7, "bp_next"};
    vecs[16] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, "drain0"};
    vecs[17] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, "drain1"};
    vecs[18] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, "drain2"};
    vecs[19] = '{8'ha5, 1'b1, 1'b1, 8'h01, 3'd0, "resume_ptr7"};
    vecs[20] = '{8'ha0, 1'b1, 1'b1, 8'h20, 3'd5, "resume_a0"};
    vecs[21] = '{8'h80, 1'b1, 1'b1, 8'h80, 3'd7, "top_bit"};
    vecs[22] = '{8'h80, 1'b0, 1'b1, 8'h80, 3'd7, "top_hold"};
    vecs[23] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, "idle"};
    vecs[24] = '{8'h10, 1'b0, 1'b1, 8'h10, 3'd4, "idle_load_noready"};
    vecs[25] = '{8'h10, 1'b0, 1'b1, 8'h10, 3'd4, "held_noready"};

    rst   = 1'b0;
    req   = 8'hff;
    ready = 1'b1;
    step(8'hff, 1'b1);
    check_out("reset0", 1'b0, 8'h00, 3'd0);
    step(8'hff, 1'b1);
    check_out("reset1", 1'b0, 8'h00, 3'd0);

    rst = 1'b1;
    step(8'hff, 1'b1);
    check_out("first_after_reset", 1'b1, 8'h01, 3'd0);

    // Re-enter reset to restart the table from ptr=7
    rst = 1'b0;
    step(8'h00, 1'b1);
    check_out("reset2", 1'b0, 8'h00, 3'd0);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].req, vecs[i].ready);
      check_out(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_hot, vecs[i].exp_bin);
      check_inv(vecs[i].name);
    end

    // Reset while a grant is held under backpressure drops it and restores ptr=7
    rst = 1'b0;
    step(8'h10, 1'b0);
    check_out("midop_reset", 1'b0, 8'h00, 3'd0);
    rst = 1'b1;
    step(8'hff, 1'b1);
    check_out("post_reset_ff0", 1'b1, 8'h01, 3'd0);
    step(8'hff, 1'b1);
    check_out("post_reset_ff1", 1'b1, 8'h02, 3'd1);

    // Fairness: full request vector rotates through every index once
    for (int i = 2; i < 10; i++) begin
      step(8'hff, 1'b1);
      check_out("full_rotate", 1'b1, 8'h01 << (i % 8), 3'(i % 8));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
